// File: rtl/cpu_pc_pkg.sv
// Shared flow-control encodings and constants for the program-counter unit.
package cpu_pc_pkg;

    typedef enum logic [2:0] {
        PC_SEQ  = 3'b000,
        PC_BEQ  = 3'b001,
        PC_BNE  = 3'b010,
        PC_JUMP = 3'b011,
        PC_CALL = 3'b100,
        PC_RET  = 3'b101
    } pc_ctrl_e;

    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack with sticky overflow/underflow flags.
module pc_ras
    import cpu_pc_pkg::*;
#(
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                i_push,
    input  logic                i_pop,
    input  logic [PC_WIDTH-1:0] i_data,
    output logic [PC_WIDTH-1:0] o_top,
    output logic                o_empty,
    output logic                o_ovf,
    output logic                o_unf
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PC_WIDTH-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0]    r_top;
    logic [CNT_W-1:0]    r_count;
    logic                r_ovf;
    logic                r_unf;
    logic [PTR_W-1:0]    w_top_inc;
    logic                w_full;

    assign w_top_inc = r_top + PTR_W'(1);
    assign w_full    = (r_count == CNT_W'(RAS_DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_top     = r_mem[r_top];
    assign o_ovf     = r_ovf;
    assign o_unf     = r_unf;

    // A push when full advances the pointer onto the oldest entry, silently dropping it.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_top   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (i_push) begin
            r_top <= w_top_inc;
            if (w_full) r_ovf <= 1'b1;
            else        r_count <= r_count + CNT_W'(1);
        end else if (i_pop) begin
            if (o_empty) begin
                r_unf <= 1'b1;
            end else begin
                r_top   <= r_top - PTR_W'(1);
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET_N && i_push) r_mem[w_top_inc] <= i_data;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: PC register, PC+4 / branch target arithmetic,
// conditional branch resolution, stall hold and CALL/RET via pc_ras.
module pc_sequencer
    import cpu_pc_pkg::*;
#(
    parameter int unsigned          PC_WIDTH     = 32,
    parameter int unsigned          OFFSET_WIDTH = 8,
    parameter int unsigned          SHIFT        = 2,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
    parameter int unsigned          RAS_DEPTH    = 4
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    BUSYWAIT,
    input  logic [2:0]              CTRL,
    input  logic                    ZERO,
    input  logic [OFFSET_WIDTH-1:0] OFFSET,
    output logic [PC_WIDTH-1:0]     PC,
    output logic [PC_WIDTH-1:0]     TARGET,
    output logic                    TAKEN,
    output logic                    RAS_OVF,
    output logic                    RAS_UNF
);

    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_seq_pc;
    logic [PC_WIDTH-1:0] w_off_ext;
    logic [PC_WIDTH-1:0] w_target;
    logic [PC_WIDTH-1:0] w_next_pc;
    logic [PC_WIDTH-1:0] w_ras_top;
    logic                w_ras_empty;
    logic                w_taken;
    logic                w_is_call;
    logic                w_is_ret;

    assign w_seq_pc  = r_pc + PC_WIDTH'(PC_INC);
    assign w_off_ext = {{(PC_WIDTH-OFFSET_WIDTH){OFFSET[OFFSET_WIDTH-1]}}, OFFSET};
    assign w_target  = w_seq_pc + (w_off_ext << SHIFT);

    // Unlisted encodings fall through to the default and behave as SEQ.
    always_comb begin
        w_taken   = 1'b0;
        w_is_call = 1'b0;
        w_is_ret  = 1'b0;
        case (pc_ctrl_e'(CTRL))
            PC_BEQ:  w_taken = ZERO;
            PC_BNE:  w_taken = ~ZERO;
            PC_JUMP: w_taken = 1'b1;
            PC_CALL: begin
                w_taken   = 1'b1;
                w_is_call = 1'b1;
            end
            PC_RET: begin
                w_is_ret = 1'b1;
                w_taken  = ~w_ras_empty;
            end
            default: ;
        endcase
    end

    assign w_next_pc = (w_is_ret && w_taken) ? w_ras_top :
                       w_taken               ? w_target  : w_seq_pc;

    always_ff @(posedge CLK) begin
        if (!RESET_N)       r_pc <= RESET_VECTOR;
        else if (!BUSYWAIT) r_pc <= w_next_pc;
    end

    pc_ras #(
        .PC_WIDTH  (PC_WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .i_push  (w_is_call & ~BUSYWAIT),
        .i_pop   (w_is_ret & ~BUSYWAIT),
        .i_data  (w_seq_pc),
        .o_top   (w_ras_top),
        .o_empty (w_ras_empty),
        .o_ovf   (RAS_OVF),
        .o_unf   (RAS_UNF)
    );

    assign PC     = r_pc;
    assign TARGET = w_target;
    assign TAKEN  = w_taken;

endmodule
